csr_rr_arbiter: RTL
===================

Name: csr_rr_arbiter

Overview:
- Shares one csr_if slave, such as a CSR register file, between NUM_M CSR masters.
- Masters include core, debug and DMA.
- Round-robin arbitration with exactly one transaction in flight.
- The response is routed back to the master that issued the request.
- Upstream side: flattened csr_if slave-side ports. Downstream side: csr_if master-side ports.

Parameters:
- NUM_M, 2, number of requesting masters (2..8).
- ADDR_W, 32, CSR address width.
- DATA_W, 32, CSR data width (multiple of 8).
- PRIV_W, 2, privilege field width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- m_req_valid  in  NUM_M  per-master request valid.
- m_req_ready  out  NUM_M  per-master request accept.
- m_req_write  in  NUM_M  per-master write flag.
- m_req_addr  in  NUM_M*ADDR_W  packed addresses; master i at [i*ADDR_W +: ADDR_W].
- m_req_wdata  in  NUM_M*DATA_W  packed write data.
- m_req_wstrb  in  NUM_M*(DATA_W/8)  packed byte strobes.
- m_req_priv  in  NUM_M*PRIV_W  packed privilege.
- m_rsp_valid  out  NUM_M  per-master response valid.
- m_rsp_ready  in  NUM_M  per-master response ready.
- m_rsp_rdata  out  DATA_W  response data, shared by all masters.
- m_rsp_fault  out  1  response fault, shared.
- m_rsp_side_effect  out  1  response side-effect flag, shared.
- s_req_valid / s_req_ready / s_req_write / s_req_addr / s_req_wdata / s_req_wstrb / s_req_priv  out/in/out/out/out/out/out  widths as csr_if  downstream request.
- s_rsp_valid / s_rsp_ready / s_rsp_rdata / s_rsp_fault / s_rsp_side_effect  in/out/in/in/in  widths as csr_if  downstream response.
- gnt_idx  out  $clog2(NUM_M)  index of the current owner, for debug.
- busy  out  1  state != IDLE.
- err_spurious_rsp  out  1  one-cycle pulse on s_rsp_valid while in IDLE.

Behaviour:
- Reset: state=IDLE, rr_ptr=0, gnt_q=0.
  - All valid/ready outputs, busy and err_spurious_rsp are 0.
  - Data outputs are 0.
  - Reset mid-transaction abandons it; the downstream slave shares rst.
- States:
  - IDLE: m_req_ready=0, s_req_valid=0, s_rsp_ready=0, m_rsp_valid=0.
    - If any m_req_valid is set, pick winner = first set bit scanning from rr_ptr upward, mod NUM_M.
    - Register gnt_q=winner and rr_ptr=(winner+1) mod NUM_M, then go to REQ.
    - No request: stay in IDLE.
  - REQ: s_req_valid=1; s_req_* fields are muxed from master gnt_q; m_req_ready[gnt_q]=s_req_ready; other m_req_ready bits are 0.
    - On s_req_ready=1:
      - If s_rsp_valid && m_rsp_ready[gnt_q] in the same cycle, the transaction completes and state goes to IDLE.
      - Otherwise go to RSP.
    - s_rsp_ready=m_rsp_ready[gnt_q] is also driven in REQ to support same-cycle responses.
  - RSP: m_rsp_valid[gnt_q]=s_rsp_valid; s_rsp_ready=m_rsp_ready[gnt_q]; m_rsp_rdata/fault/side_effect are passed through from s_rsp_*.
    - On handshake go to IDLE.
    - Other m_rsp_valid bits are always 0.
- Latency:
  - Request arrival to s_req_valid: 1 cycle (registered grant).
  - Minimum transaction occupancy: 2 cycles.
  - Back-to-back transactions: IDLE is revisited for 1 cycle between them.
- Stability:
  - gnt_q is frozen from REQ until IDLE, so s_req_* are stable under backpressure, given masters obey the csr_if hold rule.
  - Response fields are combinational pass-through, so they are stable if the slave holds them.
- Shared response buses are driven to 0 outside RSP/REQ; masters qualify them with their own m_rsp_valid.
- Fairness: a master with valid held continuously is granted within NUM_M transactions.
- rr_ptr wraps from NUM_M-1 to 0.
  - For non-power-of-2 NUM_M, indices ≥ NUM_M are never produced.
- s_rsp_valid in IDLE: it is ignored (s_rsp_ready=0) and err_spurious_rsp pulses each such cycle.
- Simulation assertions:
  - At most one bit of m_req_ready is set.
  - At most one bit of m_rsp_valid is set.
  - gnt_q < NUM_M.

Decomposition:
- carbon_csr_pkg holds:
  - the csr_arb_state_e enum {IDLE, REQ, RSP}, 2 bits;
  - a helper function clog2_min1(n) for index width, with 1 returned for n=1.
- Sub-module carbon_rr_pick is purely combinational:
  - inputs req[NUM_M], ptr;
  - outputs any, idx.
  - It is reused by future arbiters.

Test Plan:
- Single master 0 reads addr 0x0000_0C00, slave ready immediately, rsp same cycle rdata=0xDEAD_BEEF -> m_rsp_valid[0] asserted 1 cycle after request, rdata 0xDEADBEEF, back in IDLE next cycle.
- NUM_M=3, all masters valid continuously, 6 transactions -> grant order 0,1,2,0,1,2; each master's addr/wdata reach s_req_* unchanged.
- Slave holds s_req_ready=0 for 5 cycles during a master 1 write of wdata 0x1234_5678, wstrb 0xF -> s_req_* stable all 5 cycles; the master 2 request arriving meanwhile is not granted until the response completes.
- Slave response with fault=1, master holds m_rsp_ready=0 for 3 cycles -> m_rsp_valid[gnt] stays 1 with fault=1; s_rsp_ready=0; state stays RSP.
- s_rsp_valid pulsed while IDLE -> err_spurious_rsp=1 for that cycle; no m_rsp_valid asserted.
- rst asserted in RSP state -> next cycle busy=0, all ready/valid outputs 0, rr_ptr=0, so a subsequent simultaneous request from masters 0 and 1 grants master 0.

Source files
------------

// File: rtl/carbon_csr_pkg.sv
// Shared types and helpers for the CSR interconnect blocks.
package carbon_csr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } csr_arb_state_e;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/carbon_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module carbon_rr_pick
    import carbon_csr_pkg::*;
#(
    parameter int NUM_M = 2,
    parameter int IDX_W = clog2_min1(NUM_M)
) (
    input  logic [NUM_M-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    int               j;
    logic [IDX_W-1:0] jj;

    // Scan from the farthest offset down so the nearest request wins.
    always_comb begin
        any = 1'b0;
        idx = '0;
        j   = 0;
        jj  = '0;
        for (int k = NUM_M - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NUM_M) j = j - NUM_M;
            jj = IDX_W'(j);
            if (req[jj]) begin
                any = 1'b1;
                idx = jj;
            end
        end
    end

endmodule

// File: rtl/csr_rr_arbiter.sv
// Round-robin arbiter sharing one csr_if slave among NUM_M masters, one
// transaction in flight, response steered back to the granted master.
module csr_rr_arbiter
    import carbon_csr_pkg::*;
#(
    parameter int NUM_M  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int PRIV_W = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_M-1:0]             m_req_valid,
    output logic [NUM_M-1:0]             m_req_ready,
    input  logic [NUM_M-1:0]             m_req_write,
    input  logic [NUM_M*ADDR_W-1:0]      m_req_addr,
    input  logic [NUM_M*DATA_W-1:0]      m_req_wdata,
    input  logic [NUM_M*(DATA_W/8)-1:0]  m_req_wstrb,
    input  logic [NUM_M*PRIV_W-1:0]      m_req_priv,
    output logic [NUM_M-1:0]             m_rsp_valid,
    input  logic [NUM_M-1:0]             m_rsp_ready,
    output logic [DATA_W-1:0]            m_rsp_rdata,
    output logic                         m_rsp_fault,
    output logic                         m_rsp_side_effect,
    output logic                         s_req_valid,
    input  logic                         s_req_ready,
    output logic                         s_req_write,
    output logic [ADDR_W-1:0]            s_req_addr,
    output logic [DATA_W-1:0]            s_req_wdata,
    output logic [DATA_W/8-1:0]          s_req_wstrb,
    output logic [PRIV_W-1:0]            s_req_priv,
    input  logic                         s_rsp_valid,
    output logic                         s_rsp_ready,
    input  logic [DATA_W-1:0]            s_rsp_rdata,
    input  logic                         s_rsp_fault,
    input  logic                         s_rsp_side_effect,
    output logic [$clog2(NUM_M)-1:0]     gnt_idx,
    output logic                         busy,
    output logic                         err_spurious_rsp
);

    localparam int IDX_W  = clog2_min1(NUM_M);
    localparam int STRB_W = DATA_W / 8;

    csr_arb_state_e   state_q, state_d;
    logic [IDX_W-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;

    carbon_rr_pick #(.NUM_M(NUM_M), .IDX_W(IDX_W)) u_pick (
        .req (m_req_valid),
        .ptr (rr_ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        gnt_d             = gnt_q;
        rr_ptr_d          = rr_ptr_q;
        m_req_ready       = '0;
        m_rsp_valid       = '0;
        m_rsp_rdata       = '0;
        m_rsp_fault       = 1'b0;
        m_rsp_side_effect = 1'b0;
        s_req_valid       = 1'b0;
        s_req_write       = 1'b0;
        s_req_addr        = '0;
        s_req_wdata       = '0;
        s_req_wstrb       = '0;
        s_req_priv        = '0;
        s_rsp_ready       = 1'b0;
        err_spurious_rsp  = 1'b0;
        unique case (state_q)
            IDLE: begin
                err_spurious_rsp = s_rsp_valid;
                if (pick_any) begin
                    gnt_d    = pick_idx;
                    rr_ptr_d = (pick_idx == IDX_W'(NUM_M - 1)) ? '0 : pick_idx + 1'b1;
                    state_d  = REQ;
                end
            end
            REQ, RSP: begin
                // Response path is open in REQ too so a same-cycle response completes.
                m_rsp_valid[gnt_q] = s_rsp_valid;
                s_rsp_ready        = m_rsp_ready[gnt_q];
                m_rsp_rdata        = s_rsp_rdata;
                m_rsp_fault        = s_rsp_fault;
                m_rsp_side_effect  = s_rsp_side_effect;
                if (state_q == REQ) begin
                    s_req_valid        = 1'b1;
                    s_req_write        = m_req_write[gnt_q];
                    s_req_addr         = m_req_addr[int'(gnt_q)*ADDR_W +: ADDR_W];
                    s_req_wdata        = m_req_wdata[int'(gnt_q)*DATA_W +: DATA_W];
                    s_req_wstrb        = m_req_wstrb[int'(gnt_q)*STRB_W +: STRB_W];
                    s_req_priv         = m_req_priv[int'(gnt_q)*PRIV_W +: PRIV_W];
                    m_req_ready[gnt_q] = s_req_ready;
                    if (s_req_ready)
                        state_d = (s_rsp_valid && m_rsp_ready[gnt_q]) ? IDLE : RSP;
                end else if (s_rsp_valid && m_rsp_ready[gnt_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign gnt_idx = gnt_q;
    assign busy    = (state_q != IDLE);

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(m_req_ready));
            assert ($onehot0(m_rsp_valid));
            assert (int'(gnt_q) < NUM_M);
        end
    end
`endif

endmodule
